// File: rtl/fmap_rmw_if.sv
// Event, read and write ports of the feature-map read-modify-write engine.
// Coordinates are packed as {y, x}, x in the low COORD_BITS bits.
interface fmap_rmw_if #(
  parameter int COORD_BITS       = 8,
  parameter int CHANNELS         = 4,
  parameter int BITS_PER_CHANNEL = 8
);
  localparam int VW = 2 * COORD_BITS;
  localparam int DW = CHANNELS * BITS_PER_CHANNEL;

  // Every channel here is valid/ready: a beat moves in the cycle where both
  // sides are high, and the sender holds its payload stable until then.
  logic          ev_valid;
  logic          ev_ready;
  logic [VW-1:0] ev_coord;
  logic [DW-1:0] ev_weights;

  logic          read_req;
  logic [VW-1:0] coord_get;
  logic          read_ready;
  logic [DW-1:0] data_out;

  logic          write_req;
  logic [VW-1:0] coord_wtr;
  logic [DW-1:0] data_in;
  logic          write_ready;

  modport slave (
    input  ev_valid, ev_coord, ev_weights, read_ready, data_out, write_ready,
    output ev_ready, read_req, coord_get, write_req, coord_wtr, data_in
  );

  modport master (
    output ev_valid, ev_coord, ev_weights, read_ready, data_out, write_ready,
    input  ev_ready, read_req, coord_get, write_req, coord_wtr, data_in
  );
endinterface

// File: rtl/fmap_rmw_engine.sv
// Read-modify-write of one feature-map pixel word per event: read, add the
// saturated per-channel weights, write back in acceptance order.
module fmap_rmw_engine #(
  parameter int COORD_BITS       = 8,
  parameter int CHANNELS         = 4,
  parameter int BITS_PER_CHANNEL = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  fmap_rmw_if.slave   bus,
  output logic        busy,
  output logic [15:0] write_count
);
  localparam int B  = BITS_PER_CHANNEL;
  localparam int VW = 2 * COORD_BITS;
  localparam int DW = CHANNELS * B;

  logic          s1_valid, s2_valid, skid_valid, w_valid;
  logic [VW-1:0] s1_coord, s2_coord, skid_coord, w_coord;
  logic [DW-1:0] s1_weights, s2_data, skid_data, w_data;
  logic          accept, complete;
  logic [DW-1:0] base, s1_result;
  logic [B:0]    ch_sum;

  assign bus.ev_ready  = enable && bus.read_ready && bus.write_ready && !skid_valid && !rst;
  assign accept        = bus.ev_valid && bus.ev_ready;
  assign bus.read_req  = accept;
  assign bus.coord_get = accept ? bus.ev_coord : '0;

  assign complete      = s2_valid && bus.write_ready;
  assign bus.write_req = s2_valid;
  assign bus.coord_wtr = s2_valid ? s2_coord : '0;
  assign bus.data_in   = s2_valid ? s2_data : '0;
  assign busy          = s1_valid || s2_valid || skid_valid;

  // Newest pending value of this pixel wins over what memory returned.
  always_comb begin
    base = bus.data_out;
    if (s2_valid && (s2_coord == s1_coord)) begin
      base = s2_data;
    end else if (w_valid && (w_coord == s1_coord)) begin
      base = w_data;
    end
  end

  // Sign-extend to B+1 bits; a mismatch of the top two bits means overflow.
  always_comb begin
    s1_result = '0;
    ch_sum    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ch_sum = {base[i*B+B-1], base[i*B +: B]} + {s1_weights[i*B+B-1], s1_weights[i*B +: B]};
      if (ch_sum[B] != ch_sum[B-1]) begin
        s1_result[i*B +: B] = ch_sum[B] ? {1'b1, {(B-1){1'b0}}} : {1'b0, {(B-1){1'b1}}};
      end else begin
        s1_result[i*B +: B] = ch_sum[B-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      skid_valid  <= 1'b0;
      w_valid     <= 1'b0;
      write_count <= 16'd0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_coord   <= bus.ev_coord;
        s1_weights <= bus.ev_weights;
      end

      w_valid <= complete;
      if (complete) begin
        w_coord     <= s2_coord;
        w_data      <= s2_data;
        write_count <= write_count + 16'd1;
      end

      // The skid entry is older than S1, so it always refills S2 first.
      if (!s2_valid || complete) begin
        if (skid_valid) begin
          s2_valid   <= 1'b1;
          s2_coord   <= skid_coord;
          s2_data    <= skid_data;
          skid_valid <= s1_valid;
          if (s1_valid) begin
            skid_coord <= s1_coord;
            skid_data  <= s1_result;
          end
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_coord <= s1_coord;
            s2_data  <= s1_result;
          end
        end
      end else if (s1_valid) begin
        skid_valid <= 1'b1;
        skid_coord <= s1_coord;
        skid_data  <= s1_result;
      end
    end
  end
endmodule

// File: tb/tb_fmap_rmw_engine.sv
// Directed bench for fmap_rmw_engine with a one-cycle-latency memory model.
module tb_fmap_rmw_engine;
  localparam int CB = 8;
  localparam int CH = 4;
  localparam int B  = 8;
  localparam int VW = 2 * CB;
  localparam int DW = CH * B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        busy;
  logic [15:0] write_count;

  fmap_rmw_if #(.COORD_BITS(CB), .CHANNELS(CH), .BITS_PER_CHANNEL(B)) bus ();

  fmap_rmw_engine #(.COORD_BITS(CB), .CHANNELS(CH), .BITS_PER_CHANNEL(B)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bus         (bus),
    .busy        (busy),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  logic [DW-1:0] mem [0:65535];
  logic          pl_valid = 1'b0;
  logic [VW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  logic [VW-1:0] wr_coord_q [$];
  logic [DW-1:0] wr_data_q [$];
  int unsigned   wr_cyc_q [$];
  logic [DW-1:0] exp_q [$];

  // Memory: reads return one cycle later; a same-cycle write is not yet visible.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_valid) mem[pl_addr] <= pl_data;
    if (rst) bus.data_out <= '0;
    else if (bus.read_req) bus.data_out <= mem[bus.coord_get];
    if (bus.write_req && bus.write_ready) begin
      mem[bus.coord_wtr] <= bus.data_in;
      wr_coord_q.push_back(bus.coord_wtr);
      wr_data_q.push_back(bus.data_in);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [VW-1:0] addr, input logic [DW-1:0] data);
    pl_addr  = addr;
    pl_data  = data;
    pl_valid = 1'b1;
    tick();
    pl_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    enable          = 1'b1;
    bus.ev_valid    = 1'b0;
    bus.read_ready  = 1'b1;
    bus.write_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wr_coord_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_writes(input int n, output bit ok);
    for (int k = 0; k < 40 && wr_data_q.size() < n; k++) tick();
    ok = (wr_data_q.size() >= n);
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    enable          = 1'b1;
    bus.read_ready  = 1'b1;
    bus.write_ready = 1'b1;
    bus.ev_valid    = 1'b1;
    bus.ev_coord    = 16'h0102;
    bus.ev_weights  = 32'h01010101;
    tick();
    tick();
    checks++; if (bus.ev_ready !== 1'b0) begin errors++; $display("FAIL reset_ev_ready: got %b expected 0", bus.ev_ready); end
    checks++; if (bus.read_req !== 1'b0) begin errors++; $display("FAIL reset_read_req: got %b expected 0", bus.read_req); end
    checks++; if (bus.coord_get !== 16'h0) begin errors++; $display("FAIL reset_coord_get: got %h expected 0000", bus.coord_get); end
    checks++; if (bus.write_req !== 1'b0) begin errors++; $display("FAIL reset_write_req: got %b expected 0", bus.write_req); end
    checks++; if (bus.coord_wtr !== 16'h0) begin errors++; $display("FAIL reset_coord_wtr: got %h expected 0000", bus.coord_wtr); end
    checks++; if (bus.data_in !== 32'h0) begin errors++; $display("FAIL reset_data_in: got %h expected 00000000", bus.data_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (write_count !== 16'h0) begin errors++; $display("FAIL reset_write_count: got %h expected 0000", write_count); end
    bus.ev_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_event();
    int unsigned t;
    bit ok;
    do_reset();
    preload(16'h0203, 32'h00000000);
    bus.ev_valid   = 1'b1;
    bus.ev_coord   = 16'h0203;
    bus.ev_weights = 32'h04030201;
    #1;
    checks++; if (bus.ev_ready !== 1'b1) begin errors++; $display("FAIL single_ev_ready: got %b expected 1", bus.ev_ready); end
    checks++; if (bus.read_req !== 1'b1) begin errors++; $display("FAIL single_read_req: got %b expected 1", bus.read_req); end
    checks++; if (bus.coord_get !== 16'h0203) begin errors++; $display("FAIL single_coord_get: got %h expected 0203", bus.coord_get); end
    t = cyc;
    tick();
    bus.ev_valid = 1'b0;
    #1;
    checks++; if (bus.read_req !== 1'b0) begin errors++; $display("FAIL single_read_req_idle: got %b expected 0", bus.read_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    wait_writes(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_write_timeout: got %0d writes expected 1", wr_data_q.size()); end
    if (ok) begin
      checks++; if (wr_cyc_q[0] !== t + 2) begin errors++; $display("FAIL single_write_cycle: got %0d expected %0d", wr_cyc_q[0], t + 2); end
      checks++; if (wr_coord_q[0] !== 16'h0203) begin errors++; $display("FAIL single_coord_wtr: got %h expected 0203", wr_coord_q[0]); end
      checks++; if (wr_data_q[0] !== 32'h04030201) begin errors++; $display("FAIL single_data_in: got %h expected 04030201", wr_data_q[0]); end
    end
    checks++; if (write_count !== 16'd1) begin errors++; $display("FAIL single_write_count: got %0d expected 1", write_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drained: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int unsigned t;
    bit ok;
    logic [DW-1:0] exp_d;
    do_reset();
    preload(16'h0505, 32'h00000000);
    exp_q.push_back(32'h01010101);
    exp_q.push_back(32'h02020202);
    exp_q.push_back(32'h03030303);
    bus.ev_valid   = 1'b1;
    bus.ev_coord   = 16'h0505;
    bus.ev_weights = 32'h01010101;
    t = cyc;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.ev_ready !== 1'b1) begin errors++; $display("FAIL b2b_ev_ready[%0d]: got %b expected 1", i, bus.ev_ready); end
      tick();
    end
    bus.ev_valid = 1'b0;
    wait_writes(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_write_timeout: got %0d writes expected 3", wr_data_q.size()); end
    for (int i = 0; i < 3 && ok; i++) begin
      exp_d = exp_q.pop_front();
      checks++; if (wr_data_q[i] !== exp_d) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, wr_data_q[i], exp_d); end
      checks++; if (wr_cyc_q[i] !== t + 2 + i) begin errors++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", i, wr_cyc_q[i], t + 2 + i); end
    end
    checks++; if (write_count !== 16'd3) begin errors++; $display("FAIL b2b_write_count: got %0d expected 3", write_count); end
  endtask

  task automatic test_w_forward();
    int unsigned t;
    bit ok;
    do_reset();
    preload(16'h0606, 32'h10101010);
    bus.ev_coord   = 16'h0606;
    bus.ev_weights = 32'h01010101;
    bus.ev_valid   = 1'b1;
    t = cyc;
    tick();
    bus.ev_valid = 1'b0;
    tick();
    bus.ev_valid = 1'b1;
    tick();
    bus.ev_valid = 1'b0;
    wait_writes(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wfwd_write_timeout: got %0d writes expected 2", wr_data_q.size()); end
    if (ok) begin
      checks++; if (wr_data_q[0] !== 32'h11111111) begin errors++; $display("FAIL wfwd_data0: got %h expected 11111111", wr_data_q[0]); end
      checks++; if (wr_data_q[1] !== 32'h12121212) begin errors++; $display("FAIL wfwd_data1: got %h expected 12121212", wr_data_q[1]); end
      checks++; if (wr_cyc_q[1] !== t + 4) begin errors++; $display("FAIL wfwd_cycle1: got %0d expected %0d", wr_cyc_q[1], t + 4); end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    logic [VW-1:0] coords [3];
    logic [DW-1:0] wts [3];
    logic [DW-1:0] exp_d;
    coords = '{16'h0101, 16'h0202, 16'h0303};
    wts    = '{32'h14141414, 32'hECECECEC, 32'h7FFF01F0};
    do_reset();
    preload(16'h0101, 32'h78787878);
    preload(16'h0202, 32'h88888888);
    preload(16'h0303, 32'h7F817E10);
    exp_q.push_back(32'h7F7F7F7F);
    exp_q.push_back(32'h80808080);
    exp_q.push_back(32'h7F807F00);
    bus.ev_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ev_coord   = coords[i];
      bus.ev_weights = wts[i];
      tick();
    end
    bus.ev_valid = 1'b0;
    wait_writes(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_write_timeout: got %0d writes expected 3", wr_data_q.size()); end
    for (int i = 0; i < 3 && ok; i++) begin
      exp_d = exp_q.pop_front();
      checks++; if (wr_data_q[i] !== exp_d) begin errors++; $display("FAIL sat_data[%0d]: got %h expected %h", i, wr_data_q[i], exp_d); end
    end
  endtask

  task automatic test_stall();
    int unsigned t;
    bit ok;
    do_reset();
    preload(16'h0909, 32'h05050505);
    bus.ev_valid   = 1'b1;
    bus.ev_coord   = 16'h0909;
    bus.ev_weights = 32'h01020304;
    t = cyc;
    tick();
    tick();
    bus.ev_valid    = 1'b0;
    bus.write_ready = 1'b0;
    #1;
    checks++; if (bus.write_req !== 1'b1) begin errors++; $display("FAIL stall_write_req_t2: got %b expected 1", bus.write_req); end
    checks++; if (bus.data_in !== 32'h06070809) begin errors++; $display("FAIL stall_data_t2: got %h expected 06070809", bus.data_in); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy_t2: got %b expected 1", busy); end
    tick();
    checks++; if (bus.data_in !== 32'h06070809) begin errors++; $display("FAIL stall_data_t3: got %h expected 06070809", bus.data_in); end
    checks++; if (bus.ev_ready !== 1'b0) begin errors++; $display("FAIL stall_ev_ready_t3: got %b expected 0", bus.ev_ready); end
    tick();
    checks++; if (bus.coord_wtr !== 16'h0909) begin errors++; $display("FAIL stall_coord_t4: got %h expected 0909", bus.coord_wtr); end
    tick();
    bus.write_ready = 1'b1;
    #1;
    checks++; if (bus.ev_ready !== 1'b0) begin errors++; $display("FAIL stall_ev_ready_skid: got %b expected 0", bus.ev_ready); end
    checks++; if (wr_data_q.size() !== 0) begin errors++; $display("FAIL stall_no_early_write: got %0d writes expected 0", wr_data_q.size()); end
    checks++; if (bus.data_in !== 32'h06070809) begin errors++; $display("FAIL stall_data_t5: got %h expected 06070809", bus.data_in); end
    wait_writes(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_write_timeout: got %0d writes expected 2", wr_data_q.size()); end
    if (ok) begin
      checks++; if (wr_data_q[0] !== 32'h06070809) begin errors++; $display("FAIL stall_data0: got %h expected 06070809", wr_data_q[0]); end
      checks++; if (wr_data_q[1] !== 32'h07090B0D) begin errors++; $display("FAIL stall_data1: got %h expected 07090b0d", wr_data_q[1]); end
      checks++; if (wr_cyc_q[0] !== t + 5) begin errors++; $display("FAIL stall_cycle0: got %0d expected %0d", wr_cyc_q[0], t + 5); end
      checks++; if (wr_cyc_q[1] !== t + 6) begin errors++; $display("FAIL stall_cycle1: got %0d expected %0d", wr_cyc_q[1], t + 6); end
    end
    checks++; if (write_count !== 16'd2) begin errors++; $display("FAIL stall_write_count: got %0d expected 2", write_count); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    preload(16'h0404, 32'h00000000);
    bus.ev_valid   = 1'b1;
    bus.ev_coord   = 16'h0404;
    bus.ev_weights = 32'h01010101;
    tick();
    bus.ev_valid = 1'b0;
    wait_writes(1, ok);
    checks++; if (write_count !== 16'd1) begin errors++; $display("FAIL rstmid_count_before: got %0d expected 1", write_count); end
    wr_data_q.delete();
    wr_coord_q.delete();
    wr_cyc_q.delete();
    bus.ev_valid = 1'b1;
    tick();
    bus.ev_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.write_req !== 1'b0) begin errors++; $display("FAIL rstmid_write_req: got %b expected 0", bus.write_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (write_count !== 16'd0) begin errors++; $display("FAIL rstmid_write_count: got %0d expected 0", write_count); end
    checks++; if (bus.data_in !== 32'h0) begin errors++; $display("FAIL rstmid_data_in: got %h expected 00000000", bus.data_in); end
    repeat (4) tick();
    checks++; if (wr_data_q.size() !== 0) begin errors++; $display("FAIL rstmid_no_write: got %0d writes expected 0", wr_data_q.size()); end
  endtask

  task automatic test_count_wrap();
    do_reset();
    preload(16'h0000, 32'h00000000);
    bus.ev_coord   = 16'h0000;
    bus.ev_weights = 32'h00000000;
    bus.ev_valid   = 1'b1;
    repeat (65535) tick();
    bus.ev_valid = 1'b0;
    repeat (4) tick();
    checks++; if (write_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_count_max: got %h expected ffff", write_count); end
    bus.ev_valid = 1'b1;
    tick();
    bus.ev_valid = 1'b0;
    repeat (4) tick();
    checks++; if (write_count !== 16'h0000) begin errors++; $display("FAIL wrap_count_zero: got %h expected 0000", write_count); end
  endtask

  initial begin
    bus.ev_valid    = 1'b0;
    bus.ev_coord    = '0;
    bus.ev_weights  = '0;
    bus.read_ready  = 1'b0;
    bus.write_ready = 1'b0;
    test_reset();
    test_single_event();
    test_back_to_back();
    test_w_forward();
    test_saturation();
    test_stall();
    test_reset_mid();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/fmap_rmw_engine.md
FMAP_RMW_ENGINE -- requirements
Module: fmap_rmw_engine

Interface
REQ-001 Parameter COORD_BITS, default DEFAULT_COORD_BITS: width of each of x and y.
REQ-002 Parameter CHANNELS, default DEFAULT_CHANNELS: feature-map channels per pixel word.
REQ-003 Parameter BITS_PER_CHANNEL, default DEFAULT_NEURON_BITS: signed two's-complement state width per channel.
REQ-004 Ports SHALL be, in order: clk in 1, rising-edge clock.
REQ-005 rst in 1: the block has one clock; reset is synchronous and active-high.
REQ-006 enable in 1: permits acceptance of new events.
REQ-007 ev_valid in 1; ev_ready out 1: event handshake, transfer when both are high.
REQ-008 ev_coord in vec2_t: target pixel (x,y); ev_weights in CHANNELS*BITS_PER_CHANNEL: signed per-channel increments, channel i at bits [i*B +: B].
REQ-009 read_req out 1; coord_get out vec2_t; read_ready in 1; data_out in CHANNELS*BITS_PER_CHANNEL: read side toward arbiter port A.
REQ-010 write_req out 1; coord_wtr out vec2_t; data_in out CHANNELS*BITS_PER_CHANNEL; write_ready in 1: write side toward arbiter port B.
REQ-011 busy out 1: any pipeline stage occupied; write_count out 16: completed writes.

Function
REQ-012 Block SHALL be the requester end of the arbiter read/write ports: read-modify-write of one pixel word per event.
REQ-013 ev_ready SHALL equal enable && read_ready && write_ready && !skid_valid, combinationally.
REQ-014 On transfer in cycle t: read_req=1 and coord_get=ev_coord in cycle t (combinational); otherwise read_req=0, coord_get=0.
REQ-015 Read data SHALL be sampled from data_out in cycle t+1 (fixed one-cycle memory latency); stage S1 holds coord and weights during t+1.
REQ-016 S1 SHALL compute per channel sum = base + weight, saturated to [-2^(B-1), 2^(B-1)-1]; no wrap.
REQ-017 base SHALL be forwarded, priority order: S2 result if S2 valid and S2 coord == S1 coord; else W result if W valid and W coord == S1 coord; else data_out.
REQ-018 W SHALL be a register holding coord/data of the write completed in the previous cycle, valid exactly one cycle.
REQ-019 S2 SHALL be registered: write_req=S2 valid, coord_wtr/data_in=S2 contents; nominal write in cycle t+2.
REQ-020 A write completes when write_req && write_ready; S2 SHALL hold all outputs stable until completion.
REQ-021 S1 result SHALL enter S2 if S2 is empty or completing that cycle; else enter one-entry skid register; skid moves to S2 on the next completion before any S1 result.
REQ-022 Writes SHALL complete in event acceptance order.
REQ-023 write_count SHALL increment by 1 per completed write, wrapping 0xFFFF->0x0000.
REQ-024 enable low SHALL block acceptance only; in-flight events SHALL drain.
REQ-025 busy = S1 valid || S2 valid || skid valid.

Reset
REQ-026 With rst high at a clock edge: S1, S2, skid, W valids cleared; write_count=0; read_req, write_req, busy=0; coord_get, coord_wtr, data_in=0.
REQ-027 ev_ready SHALL be 0 while rst is high.
REQ-028 Reset mid-operation SHALL discard in-flight events with no write issued.

Verification
REQ-029 CHANNELS=4, B=8; memory word at (3,2)=0; one event at (3,2), weights {1,2,3,4}: read_req at t; write_req at t+2, data_in {1,2,3,4}, coord_wtr (3,2); write_count=1.
REQ-030 Back-to-back: three events at (5,5), weights all 1, cycles t..t+2, memory 0: writes at t+2..t+4 carrying 1,2,3 per channel (S2 then W forwarding).
REQ-031 Saturation: memory 120, weight +20 -> 127; memory -120, weight -20 -> -128.
REQ-032 write_ready low t+2..t+4 with two events in flight: ev_ready=0, skid fills, write_req held stable; both writes complete in order after release.
REQ-033 rst asserted one cycle after acceptance: no write_req; outputs zero; write_count=0; busy=0 next cycle.
REQ-034 write_count at 0xFFFF + one write -> 0x0000.
